// File: rtl/bit8_timer_ctrl_pkg.sv
// Shared definitions for the 8-bit interval timer controller: state encoding
// and counter width.
package bit8_timer_ctrl_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  function automatic logic is_active(input state_t s);
    return (s == S_RUN) || (s == S_HOLD);
  endfunction

endpackage

// File: rtl/bit8_timer_ctrl_tick_prescaler.sv
// Divides the clock into a one-cycle tick every PRESCALE enabled cycles.
// With PRESCALE=1 the tick is constantly high.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic CP,
  input  logic MRn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_bypass
      logic unused_in;
      assign unused_in = ^{CP, MRn, en, clr};
      assign tick = 1'b1;
    end else begin : g_div
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] cnt;

      always_ff @(posedge CP or negedge MRn) begin
        if (!MRn) begin
          cnt <= '0;
        end else if (clr) begin
          cnt <= '0;
        end else if (en) begin
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
      end

      assign tick = (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/bit8_timer_ctrl.sv
// Controller that turns a cascaded 74163-style 8-bit counter into a
// programmable interval timer (one-shot or auto-reload, pause, stop).
module bit8_timer_ctrl
  import bit8_timer_ctrl_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic             CP,
  input  logic             MRn,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic [CNT_W-1:0] preset,
  input  logic             TC_in,
  output logic             PEn,
  output logic [CNT_W-1:0] D,
  output logic             CET,
  output logic             CEP,
  output logic             busy,
  output logic             expire,
  output logic [CNT_W-1:0] expire_cnt,
  output state_t           fsm_state
);

  // Counter handshake: the counter samples PEn/CET/CEP on every CP edge.
  // PEn low means "load D this edge"; it beats CET/CEP inside the counter.

  state_t state, state_n;
  logic   mode;
  logic   tick;
  logic   in_run;
  logic   exp;

  assign in_run = (state == S_RUN);
  assign exp    = in_run & tick & TC_in & ~stop;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .CP   (CP),
    .MRn  (MRn),
    .en   (in_run),
    .clr  (state == S_IDLE),
    .tick (tick)
  );

  // Reloading on the expiry cycle itself keeps auto-reload periods gap-free.
  assign PEn = ~(((state == S_LOAD) & ~stop) | exp);
  assign CEP = in_run & tick;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = S_LOAD;
      S_LOAD: state_n = S_RUN;
      S_RUN: begin
        if (exp && !mode) state_n = S_IDLE;
        else if (pause)   state_n = S_HOLD;
      end
      S_HOLD: if (!pause) state_n = S_RUN;
      default: state_n = S_IDLE;
    endcase
    if (stop) state_n = S_IDLE;
  end

  always_ff @(posedge CP or negedge MRn) begin
    if (!MRn) begin
      state      <= S_IDLE;
      D          <= '0;
      mode       <= 1'b0;
      expire     <= 1'b0;
      expire_cnt <= '0;
      CET        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state  <= state_n;
      CET    <= is_active(state_n);
      busy   <= (state_n != S_IDLE);
      expire <= exp;
      if (state == S_IDLE && start && !stop) begin
        D          <= preset;
        mode       <= auto_reload;
        expire_cnt <= '0;
      end else if (exp) begin
        expire_cnt <= expire_cnt + 1'b1;
      end
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_bit8_timer_ctrl.sv
// Bench for bit8_timer_ctrl: two controller+counter pairs (PRESCALE 1 and 3)
// checked every cycle against a period-arithmetic reference model.
module tb_bit8_timer_ctrl;
  import bit8_timer_ctrl_pkg::*;

  logic       CP = 1'b0;
  logic       MRn;
  logic       start;
  logic       stop;
  logic       pause;
  logic       auto_reload;
  logic [7:0] preset;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Clock / reset
  always #5 CP = ~CP;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge CP);
      #1;
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int P = (g == 0) ? 1 : 3;

    logic       PEn, CET, CEP, busy, expire, TC_in;
    logic [7:0] D, expire_cnt;
    state_t     fsm_state;
    logic [7:0] q = 8'h00;

    bit8_timer_ctrl #(.PRESCALE(P)) dut (
      .CP          (CP),
      .MRn         (MRn),
      .start       (start),
      .stop        (stop),
      .pause       (pause),
      .auto_reload (auto_reload),
      .preset      (preset),
      .TC_in       (TC_in),
      .PEn         (PEn),
      .D           (D),
      .CET         (CET),
      .CEP         (CEP),
      .busy        (busy),
      .expire      (expire),
      .expire_cnt  (expire_cnt),
      .fsm_state   (fsm_state)
    );

    // Behavioural 74163 cascade (its own reset tied inactive)
    always @(posedge CP) begin
      if (!PEn)            q <= D;
      else if (CET && CEP) q <= q + 8'd1;
    end
    assign TC_in = (q == 8'hFF) && CET;

    // Reference model: run cycles left in the current period and run cycles elapsed
    logic       m_busy, m_load, m_hold, m_mode, m_expire;
    logic [7:0] m_p, m_cnt;
    int         m_left, m_elapsed;
    logic       m_exp;

    assign m_exp = m_busy && !m_load && !m_hold && (m_left == 1) && !stop;

    always @(posedge CP or negedge MRn) begin
      if (!MRn) begin
        m_busy <= 1'b0; m_load <= 1'b0; m_hold <= 1'b0; m_mode <= 1'b0;
        m_expire <= 1'b0; m_p <= 8'h00; m_cnt <= 8'h00;
        m_left <= 0; m_elapsed <= 0;
      end else begin
        m_expire <= m_exp;
        if (m_exp) m_cnt <= m_cnt + 8'd1;
        if (stop) begin
          m_busy <= 1'b0; m_load <= 1'b0; m_hold <= 1'b0;
        end else if (!m_busy) begin
          if (start) begin
            m_busy <= 1'b1; m_load <= 1'b1; m_p <= preset; m_mode <= auto_reload;
            m_cnt <= 8'h00; m_left <= (256 - int'(preset)) * P; m_elapsed <= 0;
          end
        end else if (m_load) begin
          m_load <= 1'b0;
        end else if (m_hold) begin
          if (!pause) m_hold <= 1'b0;
        end else if (m_exp) begin
          if (!m_mode) begin
            m_busy <= 1'b0;
          end else begin
            m_left <= (256 - int'(m_p)) * P; m_elapsed <= 0; m_hold <= pause;
          end
        end else begin
          m_left <= m_left - 1; m_elapsed <= m_elapsed + 1; m_hold <= pause;
        end
      end
    end

    // Scoreboard: every cycle, away from the active edge
    logic [7:0] exp_q[$];
    always @(negedge CP) begin
      logic running;
      running = m_busy && !m_load;
      exp_q.push_back(8'(int'(m_p) + m_elapsed / P));
      check_eq($sformatf("i%0d_pen", g), {7'd0, PEn}, {7'd0, !((m_load && !stop) || m_exp)});
      check_eq($sformatf("i%0d_cet", g), {7'd0, CET}, {7'd0, running});
      check_eq($sformatf("i%0d_cep", g), {7'd0, CEP},
               {7'd0, running && !m_hold && ((m_elapsed % P) == P - 1)});
      check_eq($sformatf("i%0d_busy", g), {7'd0, busy}, {7'd0, m_busy});
      check_eq($sformatf("i%0d_expire", g), {7'd0, expire}, {7'd0, m_expire});
      check_eq($sformatf("i%0d_cnt", g), expire_cnt, m_cnt);
      check_eq($sformatf("i%0d_d", g), D, m_p);
      check_eq($sformatf("i%0d_state", g), {6'd0, fsm_state},
               !m_busy ? 8'd0 : m_load ? 8'd1 : m_hold ? 8'd3 : 8'd2);
      if (running) check_eq($sformatf("i%0d_q", g), q, exp_q[$]);
      exp_q.delete();
    end
  end

  task automatic launch(input logic [7:0] p, input logic ar);
    preset = p; auto_reload = ar; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Driver
  initial begin
    MRn = 1'b0; start = 1'b1; stop = 1'b0; pause = 1'b0;
    auto_reload = 1'b0; preset = 8'hFA;
    step(4);
    start = 1'b0;
    MRn = 1'b1;
    step(2);

    launch(8'hFA, 1'b0); step(20);            // one-shot, both prescalers
    launch(8'hFC, 1'b1); step(14);            // auto-reload periods
    stop = 1'b1; step(); stop = 1'b0; step(2);
    launch(8'hFE, 1'b0); step(10);            // prescaled short period
    launch(8'hFF, 1'b1); step(8);             // preset FF: TC right after load
    stop = 1'b1; step(); stop = 1'b0; step(2);
    launch(8'hF8, 1'b0); step(3);             // pause mid-count
    pause = 1'b1; step(5); pause = 1'b0; step(30);

    launch(8'hFC, 1'b1);                      // stop exactly on terminal count
    begin
      int k;
      for (k = 0; k < 40; k++) begin
        if (g_inst[0].TC_in) break;
        step();
      end
      check_eq("tc_wait", {7'd0, g_inst[0].TC_in}, 8'd1);
    end
    stop = 1'b1; step(); stop = 1'b0; step(3);

    launch(8'hF0, 1'b1); step(6);             // reset in the middle of a run
    MRn = 1'b0; step(2); MRn = 1'b1; step(2);

    for (int c = 0; c < 6000; c++) begin
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      auto_reload = 1'($urandom_range(0, 1));
      preset = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                           : 8'($urandom_range(8'hE8, 8'hFF));
      MRn = ($urandom_range(0, 999) != 0);
      step();
    end
    MRn = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    step(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
